mod_exp_arbiter: RTL

MOD_EXP_ARBITER -- requirements
Module: mod_exp_arbiter

---
 rtl/mod_exp_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mod_exp_arbiter.sv
// mod_exp_arbiter: shares one modular-exponentiation engine between two
// requesters. One request is in flight at a time: it is granted in IDLE,
// issued to the engine, its result (or a timeout error) is delivered back
// to the granted requester, and only then is the next grant considered.
module mod_exp_arbiter #(
   parameter int SIZE    = 64,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst_n,

   // Request channels, requester i in bit i / slice [i*SIZE +: SIZE]
   input  logic [1:0]        req_tvalid,
   output logic [1:0]        req_tready,
   input  logic [2*SIZE-1:0] req_base,
   input  logic [2*SIZE-1:0] req_power,
   input  logic [2*SIZE-1:0] req_modulus,

   // Result channels, data shared, valid per requester
   output logic [SIZE-1:0]   res_tdata,
   output logic [1:0]        res_tvalid,
   input  logic [1:0]        res_tready,
   output logic              res_terror,

   // Engine operand side
   output logic [SIZE-1:0]   me_base,
   output logic [SIZE-1:0]   me_power,
   output logic [SIZE-1:0]   me_modulus,
   output logic              me_tvalid,
   input  logic              me_tready,

   // Engine result side
   input  logic [SIZE-1:0]   me_result,
   input  logic              me_result_tvalid,
   output logic              me_result_tready,
   output logic              me_rst
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DELIVER
   } state_t;

   // The timer runs from ISSUE entry; the request expires in the cycle the
   // timer holds TIMEOUT-1, so the engine gets exactly TIMEOUT cycles.
   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic              grant_q, grant_d;
   logic              last_grant_q, last_grant_d;
   logic [15:0]       timer_q, timer_d;
   logic [SIZE-1:0]   me_base_q, me_base_d;
   logic [SIZE-1:0]   me_power_q, me_power_d;
   logic [SIZE-1:0]   me_modulus_q, me_modulus_d;
   logic [SIZE-1:0]   res_data_q, res_data_d;
   logic              res_error_q, res_error_d;
   logic              me_rst_q, me_rst_d;

   logic              grant_sel;
   logic [SIZE-1:0]   sel_base;
   logic [SIZE-1:0]   sel_power;
   logic [SIZE-1:0]   sel_modulus;

   // Arbitration: a lone requester wins; on a tie the one not served last wins.
   // NOTE: every variable assigned in an always_comb gets a default first, so
   // no path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      grant_sel = 1'b0;
      case (req_tvalid)
         2'b01:   grant_sel = 1'b0;
         2'b10:   grant_sel = 1'b1;
         2'b11:   grant_sel = ~last_grant_q;
         default: grant_sel = 1'b0;
      endcase
   end

   // Operand slices of the requester that would be granted this cycle.
   always_comb begin
      sel_base    = grant_sel ? req_base[2*SIZE-1:SIZE]    : req_base[SIZE-1:0];
      sel_power   = grant_sel ? req_power[2*SIZE-1:SIZE]   : req_power[SIZE-1:0];
      sel_modulus = grant_sel ? req_modulus[2*SIZE-1:SIZE] : req_modulus[SIZE-1:0];
   end

   // Next-state logic: grant, issue, wait with timeout, deliver.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      timer_d      = timer_q;
      me_base_d    = me_base_q;
      me_power_d   = me_power_q;
      me_modulus_d = me_modulus_q;
      res_data_d   = res_data_q;
      res_error_d  = res_error_q;
      me_rst_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            // req_tready is raised for the selected requester whenever any
            // request is valid, so a valid request here is a handshake.
            if (req_tvalid != 2'b00) begin
               grant_d      = grant_sel;
               me_base_d    = sel_base;
               me_power_d   = sel_power;
               me_modulus_d = sel_modulus;
               timer_d      = '0;
               state_d      = S_ISSUE;
            end
         end

         S_ISSUE: begin
            timer_d = timer_q + 16'd1;
            if (timer_q == TIMER_LAST) begin
               // Engine never took the operands: abort and report an error.
               me_rst_d    = 1'b1;
               res_data_d  = '0;
               res_error_d = 1'b1;
               state_d     = S_DELIVER;
            end else if (me_tready) begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            timer_d = timer_q + 16'd1;
            // A result arriving in the expiry cycle still counts as on time.
            if (me_result_tvalid) begin
               res_data_d  = me_result;
               res_error_d = 1'b0;
               state_d     = S_DELIVER;
            end else if (timer_q == TIMER_LAST) begin
               me_rst_d    = 1'b1;
               res_data_d  = '0;
               res_error_d = 1'b1;
               state_d     = S_DELIVER;
            end
         end

         S_DELIVER: begin
            // Only the granted requester's ready completes delivery.
            if (res_tready[grant_q]) begin
               last_grant_d = grant_q;
               state_d      = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of block order.
   // NOTE: the operand and result data registers are reset as well; there is
   // no RAM here, and zeroed outputs out of reset are part of the contract.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         timer_q      <= '0;
         me_base_q    <= '0;
         me_power_q   <= '0;
         me_modulus_q <= '0;
         res_data_q   <= '0;
         res_error_q  <= 1'b0;
         me_rst_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         timer_q      <= timer_d;
         me_base_q    <= me_base_d;
         me_power_q   <= me_power_d;
         me_modulus_q <= me_modulus_d;
         res_data_q   <= res_data_d;
         res_error_q  <= res_error_d;
         me_rst_q     <= me_rst_d;
      end
   end

   // Handshake outputs decoded from the current state.
   always_comb begin
      req_tready       = 2'b00;
      res_tvalid       = 2'b00;
      me_tvalid        = 1'b0;
      me_result_tready = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Gated by rst_n so nothing is accepted while reset is held.
            if (rst_n) begin
               req_tready = {grant_sel, ~grant_sel} & req_tvalid;
            end
         end
         S_ISSUE:   me_tvalid        = 1'b1;
         S_WAIT:    me_result_tready = 1'b1;
         S_DELIVER: res_tvalid       = {grant_q, ~grant_q};
         default:   ;
      endcase
   end

   assign me_base    = me_base_q;
   assign me_power   = me_power_q;
   assign me_modulus = me_modulus_q;
   assign res_tdata  = res_data_q;
   assign res_terror = res_error_q;
   assign me_rst     = me_rst_q;

   // Structural invariants of the handshake outputs.
   a_req_tready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(req_tready));
   a_res_tvalid_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(res_tvalid));
   a_me_rst_with_error : assert property (@(posedge clk) disable iff (!rst_n)
      me_rst |-> (res_tvalid != 2'b00 && res_terror));

endmodule
